// File: rtl/pipelined_addsub.sv
// Pipelined segmented carry-lookahead adder/subtractor with valid/ready handshake.
// One SEG_WIDTH-bit CLA segment is resolved per stage; the inter-segment carry
// is registered between stages. Flags are produced alongside the final sum.

// One SEG_WIDTH-bit carry-lookahead segment.
module pipelined_addsub_cla #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  logic [SW-1:0] g, p;
  logic [SW:0]   c;
  logic          acc, pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the OR of every lower generate ANDed with the propagates
  // above it, plus the seed propagated through all bits below.
  always_comb begin
    c   = '0;
    acc = 1'b0;
    pp  = 1'b1;
    c[0] = ci;
    for (int i = 0; i < SW; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s  = p ^ c[SW-1:0];
  assign co = c[SW];
endmodule

module pipelined_addsub #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int SW     = SEG_WIDTH;
  localparam int STAGES = WIDTH / SEG_WIDTH;

  if (SEG_WIDTH <= 0 || WIDTH <= 0 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  logic             advance, fire, seed;
  logic [WIDTH-1:0] b_cond;

  // Whole pipe moves as one; it may move whenever the output slot is free or draining.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign fire     = in_valid & advance;

  // Subtract is A + ~B + 1; c_in only matters when adding.
  assign b_cond = sub ? ~b : b;
  assign seed   = sub ? 1'b1 : c_in;

  // vld_pipe[k] is the valid bit entering stage k; vld_pipe[STAGES] is out_valid.
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  assign vld_pipe  = {vld_q, fire};
  assign out_valid = vld_pipe[STAGES];

  // Valid shift register; bubbles travel like data and are never squeezed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  // x: operand A in place, with already-resolved segments overwritten by sum.
  // y: conditioned B shifted right so the segment being added sits at [SW-1:0].
  logic [WIDTH-1:0] x_pipe  [STAGES];
  logic [WIDTH-1:0] y_pipe  [STAGES];
  logic             cy_pipe [STAGES];

  assign x_pipe[0]  = a;
  assign y_pipe[0]  = b_cond;
  assign cy_pipe[0] = seed;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    seg_s;
    logic             seg_co;
    logic [WIDTH-1:0] x_nxt;

    pipelined_addsub_cla #(.SW(SW)) u_cla (
      .a  (x_pipe[k][k*SW +: SW]),
      .b  (y_pipe[k][SW-1:0]),
      .ci (cy_pipe[k]),
      .s  (seg_s),
      .co (seg_co)
    );

    // Drop this segment's sum into its final bit position.
    always_comb begin
      x_nxt = x_pipe[k];
      x_nxt[k*SW +: SW] = seg_s;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] x_q, y_q;
      logic             cy_q;

      // Load only on a real operation so bubbles leave stale data untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q  <= '0;
          y_q  <= '0;
          cy_q <= 1'b0;
        end else if (advance && vld_pipe[k]) begin
          x_q  <= x_nxt;
          y_q  <= y_pipe[k] >> SW;
          cy_q <= seg_co;
        end
      end

      assign x_pipe[k+1]  = x_q;
      assign y_pipe[k+1]  = y_q;
      assign cy_pipe[k+1] = seg_co_unused_guard(cy_q);
    end else begin : g_last
      logic msb_cin;
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign msb_cin = seg_s[SW-1] ^ x_pipe[k][WIDTH-1] ^ y_pipe[k][SW-1];

      // Output register: updates only for valid results, holds through bubbles and stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum   <= '0;
          c_out <= 1'b0;
          ovf   <= 1'b0;
          zero  <= 1'b0;
          neg   <= 1'b0;
        end else if (advance && vld_pipe[k]) begin
          sum   <= x_nxt;
          c_out <= seg_co;
          ovf   <= seg_co ^ msb_cin;
          zero  <= ~|x_nxt;
          neg   <= x_nxt[WIDTH-1];
        end
      end
    end
  end

  // Identity helper kept as a function so the carry hop reads as a named step.
  function automatic logic seg_co_unused_guard(input logic c);
    return c;
  endfunction
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 32-bit table stream, stall/drain,
// asynchronous reset mid-flight, 64-bit (4 stages) and 8-bit (1 stage) instances.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        in_valid, out_ready, c_in, sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, c_out, ovf, zero, neg;
  logic [31:0] sum;

  // 64-bit, 4-stage instance
  logic        in_valid64, c_in64, sub64;
  logic [63:0] a64, b64;
  logic        in_ready64, out_valid64, c_out64, ovf64, zero64, neg64;
  logic [63:0] sum64;

  // 8-bit, 1-stage instance
  logic        in_valid8, c_in8, sub8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8, c_out8, ovf8, zero8, neg8;
  logic [7:0]  sum8;

  pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(16)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf),
    .zero(zero), .neg(neg));

  pipelined_addsub #(.WIDTH(64), .SEG_WIDTH(16)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .c_in(c_in64), .sub(sub64), .out_valid(out_valid64),
    .out_ready(1'b1), .sum(sum64), .c_out(c_out64), .ovf(ovf64),
    .zero(zero64), .neg(neg64));

  pipelined_addsub #(.WIDTH(8), .SEG_WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c_in8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(1'b1), .sum(sum8), .c_out(c_out8), .ovf(ovf8),
    .zero(zero8), .neg(neg8));

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] s;
    logic        c, v, z, n;
  } vec_t;

  localparam int N = 12;
  vec_t tbl [N];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv32(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ici, input logic isb);
    in_valid = v; a = ia; b = ib; c_in = ici; sub = isb;
  endtask

  initial begin
    //            a             b             ci    sb    sum           c     v     z     n
    tbl[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    drv32(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; c_in64 = 1'b0; sub64 = 1'b0;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; c_in8  = 1'b0; sub8  = 1'b0;

    // Reset state
    step(); step();
    chk("reset out32", {out_valid, sum, c_out, ovf, zero, neg}, 37'h0);
    chk("reset out64", {out_valid64, sum64}, 65'h0);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", {in_ready, in_ready64, in_ready8}, 3'b111);

    // Back-to-back table stream, out_ready held high
    for (int j = 0; j <= N + 1; j++) begin
      if (j < N) drv32(1'b1, tbl[j].a, tbl[j].b, tbl[j].ci, tbl[j].sb);
      else       in_valid = 1'b0;
      step();
      if (j >= 1 && j <= N) begin
        chk($sformatf("vec%0d valid", j - 1), {out_valid, in_ready}, 2'b11);
        chk($sformatf("vec%0d result", j - 1), {sum, c_out, ovf, zero, neg},
            {tbl[j-1].s, tbl[j-1].c, tbl[j-1].v, tbl[j-1].z, tbl[j-1].n});
      end else if (j == 0) begin
        chk("stream first edge", out_valid, 1'b0);
      end else begin
        chk("stream tail bubble", {out_valid, sum}, {1'b0, tbl[N-1].s});
      end
    end

    // Stall with full pipe, then drain
    out_ready = 1'b0;
    drv32(1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
    step();
    drv32(1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
    step();
    drv32(1'b1, 32'h100, 32'h1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d ready", i), in_ready, 1'b0);
      chk($sformatf("stall%0d hold", i), {out_valid, sum, c_out, zero}, {1'b1, 32'h3, 1'b0, 1'b0});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("drain B", {out_valid, sum}, {1'b1, 32'h30});
    step();
    chk("drain C", {out_valid, sum, c_out}, {1'b1, 32'hFF, 1'b1});
    step();
    chk("drain empty", {out_valid, sum}, {1'b0, 32'hFF});

    // Asynchronous reset with ops in flight
    drv32(1'b1, 32'h7, 32'h8, 1'b0, 1'b0);
    step();
    drv32(1'b1, 32'h9, 32'h9, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("pre-reset D", {out_valid, sum}, {1'b1, 32'hF});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset", {out_valid, sum}, {1'b0, 32'h0});
    step();
    rst_n = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (out_valid) stale++;
      end
      chk("no stale after reset", stale, 0);
    end

    // 64-bit, four stages
    for (int j = 0; j <= 6; j++) begin
      in_valid64 = 1'b1; c_in64 = 1'b0; sub64 = 1'b0;
      case (j)
        0: begin a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'h1; end
        1: begin a64 = 64'h0123456789ABCDEF; b64 = 64'hFEDCBA9876543210; end
        2: begin a64 = 64'h0000000100000000; b64 = 64'h1; sub64 = 1'b1; end
        default: in_valid64 = 1'b0;
      endcase
      step();
      case (j)
        3: chk("w64 carry chain", {out_valid64, sum64, c_out64, ovf64, zero64, neg64},
               {1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        4: chk("w64 all ones", {out_valid64, sum64, c_out64, ovf64, zero64, neg64},
               {1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
        5: chk("w64 borrow chain", {out_valid64, sum64, c_out64, ovf64, zero64, neg64},
               {1'b1, 64'h00000000FFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0});
        6: chk("w64 empty", out_valid64, 1'b0);
        default: chk($sformatf("w64 latency edge%0d", j), out_valid64, 1'b0);
      endcase
    end

    // 8-bit, single stage
    for (int j = 0; j <= 2; j++) begin
      in_valid8 = 1'b1; c_in8 = 1'b0;
      case (j)
        0: begin a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; end
        1: begin a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1; end
        default: in_valid8 = 1'b0;
      endcase
      step();
      case (j)
        0: chk("w8 wrap", {out_valid8, sum8, c_out8, ovf8, zero8, neg8},
               {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        1: chk("w8 sub ovf", {out_valid8, sum8, c_out8, ovf8, zero8, neg8},
               {1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0});
        default: chk("w8 hold", {out_valid8, sum8}, {1'b0, 8'h7F});
      endcase
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
